// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile link sequencer: lane address codes,
// frame geometry, sequencer state encoding and small helper functions.
package systolic_pkg;

  localparam logic [1:0] ADDR_PASS = 2'd0;
  localparam logic [1:0] ADDR_AB   = 2'd1;
  localparam logic [1:0] ADDR_C02  = 2'd2;
  localparam logic [1:0] ADDR_C13  = 2'd3;

  localparam int FRAME_LEN = 4;
  localparam int NIB_W     = 4;
  localparam int WORD_W    = FRAME_LEN * NIB_W;
  localparam int CTRL_W    = FRAME_LEN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } seq_state_e;

  // Control word sent alongside a data word: address in the top two bits.
  function automatic logic [CTRL_W-1:0] frame_ctrl(input logic [1:0] addr);
    return {addr, 2'b00};
  endfunction

  // Saturating 16-bit increment used by the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/systolic_lane_ser.sv
// One-lane frame serialiser: holds a 16-bit data word and 4-bit control word
// for the current frame and drives the registered nibble/bit for each fcnt slot.
// A new frame is loaded on the fcnt==3 cycle so its first nibble appears at fcnt==0.
module systolic_lane_ser
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        fcnt,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic [NIB_W-1:0]  nib,
  output logic              ctrl
);

  logic [WORD_W-1:0] word_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [WORD_W-1:0] word_s;
  logic [CTRL_W-1:0] ctrl_s;
  logic [1:0]        idx_s;
  logic [NIB_W-1:0]  nib_s;
  logic              bit_s;

  // Select the frame being sent next cycle and the slot it occupies.
  always_comb begin
    word_s = word_r;
    ctrl_s = ctrl_r;
    if (load) begin
      word_s = load_word;
      ctrl_s = load_ctrl;
    end else begin
      word_s = word_r;
      ctrl_s = ctrl_r;
    end
    idx_s = fcnt + 2'd1;
    case (idx_s)
      2'd0:    begin nib_s = word_s[15:12]; bit_s = ctrl_s[3]; end
      2'd1:    begin nib_s = word_s[11:8];  bit_s = ctrl_s[2]; end
      2'd2:    begin nib_s = word_s[7:4];   bit_s = ctrl_s[1]; end
      2'd3:    begin nib_s = word_s[3:0];   bit_s = ctrl_s[0]; end
      default: begin nib_s = 4'd0;          bit_s = 1'b0;      end
    endcase
  end

  // Frame holding registers and registered lane outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= 16'd0;
      ctrl_r <= 4'd0;
      nib    <= 4'd0;
      ctrl   <= 1'b0;
    end else begin
      word_r <= word_s;
      ctrl_r <= ctrl_s;
      nib    <= nib_s;
      ctrl   <= bit_s;
    end
  end

endmodule

// File: rtl/systolic_frame_sequencer.sv
// Host-side scheduler for the nibble-serial systolic tile link. Accepts word
// commands, serialises them over 4-cycle frames, inserts idle frames, runs
// drain sequences and deserialises returning frames into word responses.
// Optional statistics counters are built when SYSTOLIC_SEQ_STATS_EN is defined.
module systolic_frame_sequencer
  import systolic_pkg::*;
#(
  parameter int DRAIN_FRAMES = 2,
  parameter int RX_PHASE     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_col_addr,
  input  logic [1:0]  cmd_row_addr,
  input  logic [15:0] cmd_col_word,
  input  logic [15:0] cmd_row_word,
  input  logic        drain_req,
  output logic        busy,
  output logic        drain_done,
  output logic [3:0]  col_nib,
  output logic        col_ctrl,
  output logic [3:0]  row_nib,
  output logic        row_ctrl,
  input  logic [3:0]  ret_col_nib,
  input  logic        ret_col_ctrl,
  input  logic [3:0]  ret_row_nib,
  input  logic        ret_row_ctrl,
  output logic        rsp_valid,
  output logic [1:0]  rsp_col_addr,
  output logic [1:0]  rsp_row_addr,
  output logic [15:0] rsp_col_word,
  output logic [15:0] rsp_row_word
`ifdef SYSTOLIC_SEQ_STATS_EN
  ,
  output logic [15:0] stat_mac,
  output logic [15:0] stat_rsp
`endif
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_FRAMES - 1);
  localparam logic [1:0] RX_PH      = 2'(RX_PHASE);

  logic [1:0]  fcnt_r;
  seq_state_e  state_r;
  logic        drain_flag_r;
  logic [7:0]  drain_cnt_r;

  logic [1:0]  fcnt_s;
  seq_state_e  state_s;
  logic        drain_flag_s;
  logic [7:0]  drain_cnt_s;
  logic        drain_done_s;
  logic        frame_end_s;
  logic        accept_s;
  logic        drain_want_s;

  logic [15:0] tx_col_word_s;
  logic [15:0] tx_row_word_s;
  logic [3:0]  tx_col_ctrl_s;
  logic [3:0]  tx_row_ctrl_s;

  logic [11:0] rx_col_sh_r;
  logic [11:0] rx_row_sh_r;
  logic [2:0]  rx_colc_sh_r;
  logic [2:0]  rx_rowc_sh_r;
  logic        rx_hit_s;

  assign accept_s = cmd_valid && cmd_ready;

  // Sequencer next state, sticky drain flag, drain frame count and frame contents.
  always_comb begin
    fcnt_s        = fcnt_r + 2'd1;
    frame_end_s   = (fcnt_r == 2'd3);
    drain_want_s  = drain_flag_r || drain_req;
    state_s       = state_r;
    drain_cnt_s   = drain_cnt_r;
    drain_flag_s  = drain_flag_r;
    drain_done_s  = 1'b0;
    tx_col_word_s = 16'd0;
    tx_row_word_s = 16'd0;
    tx_col_ctrl_s = 4'd0;
    tx_row_ctrl_s = 4'd0;

    case (state_r)
      IDLE, STREAM: begin
        if (frame_end_s && accept_s) begin
          state_s = STREAM;
        end else if (frame_end_s && drain_want_s) begin
          state_s     = DRAIN;
          drain_cnt_s = 8'd0;
        end else if (frame_end_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      DRAIN: begin
        if (frame_end_s && (drain_cnt_r == DRAIN_LAST)) begin
          state_s = IDLE;
        end else if (frame_end_s) begin
          drain_cnt_s = drain_cnt_r + 8'd1;
        end else begin
          state_s = DRAIN;
        end
        if ((fcnt_r == 2'd2) && (drain_cnt_r == DRAIN_LAST)) begin
          drain_done_s = 1'b1;
        end else begin
          drain_done_s = 1'b0;
        end
      end
      default: begin
        state_s     = IDLE;
        drain_cnt_s = 8'd0;
      end
    endcase

    // Drain requests are remembered until DRAIN starts; ignored while draining.
    if ((state_s == DRAIN) && (state_r != DRAIN)) begin
      drain_flag_s = 1'b0;
    end else if (drain_req && (state_r != DRAIN)) begin
      drain_flag_s = 1'b1;
    end else begin
      drain_flag_s = drain_flag_r;
    end

    if (accept_s) begin
      tx_col_word_s = cmd_col_word;
      tx_row_word_s = cmd_row_word;
      tx_col_ctrl_s = frame_ctrl(cmd_col_addr);
      tx_row_ctrl_s = frame_ctrl(cmd_row_addr);
    end else begin
      tx_col_word_s = 16'd0;
      tx_row_word_s = 16'd0;
      tx_col_ctrl_s = 4'd0;
      tx_row_ctrl_s = 4'd0;
    end
  end

  // Frame counter, FSM state and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_r       <= 2'd0;
      state_r      <= IDLE;
      drain_flag_r <= 1'b0;
      drain_cnt_r  <= 8'd0;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      drain_done   <= 1'b0;
    end else begin
      fcnt_r       <= fcnt_s;
      state_r      <= state_s;
      drain_flag_r <= drain_flag_s;
      drain_cnt_r  <= drain_cnt_s;
      cmd_ready    <= (fcnt_s == 2'd3) && (state_s != DRAIN);
      busy         <= (state_s != IDLE) || drain_flag_s;
      drain_done   <= drain_done_s;
    end
  end

  systolic_lane_ser u_col_ser (
    .clk       (clk),
    .rst       (rst),
    .fcnt      (fcnt_r),
    .load      (frame_end_s),
    .load_word (tx_col_word_s),
    .load_ctrl (tx_col_ctrl_s),
    .nib       (col_nib),
    .ctrl      (col_ctrl)
  );

  systolic_lane_ser u_row_ser (
    .clk       (clk),
    .rst       (rst),
    .fcnt      (fcnt_r),
    .load      (frame_end_s),
    .load_word (tx_row_word_s),
    .load_ctrl (tx_row_ctrl_s),
    .nib       (row_nib),
    .ctrl      (row_ctrl)
  );

  // A returning frame carries something when either address (ctrl[3:2]) is non-pass.
  assign rx_hit_s = (fcnt_r == RX_PH) &&
                    ((rx_colc_sh_r[2:1] != ADDR_PASS) || (rx_rowc_sh_r[2:1] != ADDR_PASS));

  // Receive shift registers and response capture on the last nibble of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_col_sh_r  <= 12'd0;
      rx_row_sh_r  <= 12'd0;
      rx_colc_sh_r <= 3'd0;
      rx_rowc_sh_r <= 3'd0;
      rsp_valid    <= 1'b0;
      rsp_col_addr <= 2'd0;
      rsp_row_addr <= 2'd0;
      rsp_col_word <= 16'd0;
      rsp_row_word <= 16'd0;
    end else begin
      rx_col_sh_r  <= {rx_col_sh_r[7:0], ret_col_nib};
      rx_row_sh_r  <= {rx_row_sh_r[7:0], ret_row_nib};
      rx_colc_sh_r <= {rx_colc_sh_r[1:0], ret_col_ctrl};
      rx_rowc_sh_r <= {rx_rowc_sh_r[1:0], ret_row_ctrl};
      rsp_valid    <= rx_hit_s;
      if (rx_hit_s) begin
        rsp_col_addr <= rx_colc_sh_r[2:1];
        rsp_row_addr <= rx_rowc_sh_r[2:1];
        rsp_col_word <= {rx_col_sh_r, ret_col_nib};
        rsp_row_word <= {rx_row_sh_r, ret_row_nib};
      end else begin
        rsp_col_addr <= rsp_col_addr;
        rsp_row_addr <= rsp_row_addr;
        rsp_col_word <= rsp_col_word;
        rsp_row_word <= rsp_row_word;
      end
    end
  end

`ifdef SYSTOLIC_SEQ_STATS_EN
  // Saturating counters of MAC frames sent and responses delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_mac <= 16'd0;
      stat_rsp <= 16'd0;
    end else begin
      if (accept_s && (cmd_col_addr == ADDR_AB) && (cmd_row_addr == ADDR_AB)) begin
        stat_mac <= sat_inc16(stat_mac);
      end else begin
        stat_mac <= stat_mac;
      end
      if (rx_hit_s) begin
        stat_rsp <= sat_inc16(stat_rsp);
      end else begin
        stat_rsp <= stat_rsp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_frame_sequencer.sv
// Directed self-checking bench for systolic_frame_sequencer.
module tb_systolic_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_col_addr;
  logic [1:0]  cmd_row_addr;
  logic [15:0] cmd_col_word;
  logic [15:0] cmd_row_word;
  logic        drain_req;
  logic        busy;
  logic        drain_done;
  logic [3:0]  col_nib;
  logic        col_ctrl;
  logic [3:0]  row_nib;
  logic        row_ctrl;
  logic [3:0]  ret_col_nib;
  logic        ret_col_ctrl;
  logic [3:0]  ret_row_nib;
  logic        ret_row_ctrl;
  logic        rsp_valid;
  logic [1:0]  rsp_col_addr;
  logic [1:0]  rsp_row_addr;
  logic [15:0] rsp_col_word;
  logic [15:0] rsp_row_word;
`ifdef SYSTOLIC_SEQ_STATS_EN
  logic [15:0] stat_mac;
  logic [15:0] stat_rsp;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int tb_fcnt = 0;

  systolic_frame_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_col_addr (cmd_col_addr),
    .cmd_row_addr (cmd_row_addr),
    .cmd_col_word (cmd_col_word),
    .cmd_row_word (cmd_row_word),
    .drain_req    (drain_req),
    .busy         (busy),
    .drain_done   (drain_done),
    .col_nib      (col_nib),
    .col_ctrl     (col_ctrl),
    .row_nib      (row_nib),
    .row_ctrl     (row_ctrl),
    .ret_col_nib  (ret_col_nib),
    .ret_col_ctrl (ret_col_ctrl),
    .ret_row_nib  (ret_row_nib),
    .ret_row_ctrl (ret_row_ctrl),
    .rsp_valid    (rsp_valid),
    .rsp_col_addr (rsp_col_addr),
    .rsp_row_addr (rsp_row_addr),
    .rsp_col_word (rsp_col_word),
    .rsp_row_word (rsp_row_word)
`ifdef SYSTOLIC_SEQ_STATS_EN
    ,
    .stat_mac     (stat_mac),
    .stat_rsp     (stat_rsp)
`endif
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; tb_fcnt tracks the frame slot of the cycle now current.
  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    tb_fcnt = r ? 0 : ((tb_fcnt + 1) % 4);
  endtask

  task automatic to_fcnt3();
    while (tb_fcnt != 3) tick();
  endtask

  // Drive one returning frame starting at an fcnt==0 cycle, then idle the inputs.
  task automatic rx_frame(input logic [15:0] cw, input logic [3:0] cc,
                          input logic [15:0] rw, input logic [3:0] rc);
    for (int k = 0; k < 4; k++) begin
      ret_col_nib  = cw[15-4*k -: 4];
      ret_row_nib  = rw[15-4*k -: 4];
      ret_col_ctrl = cc[3-k];
      ret_row_ctrl = rc[3-k];
      tick();
    end
    ret_col_nib  = 4'd0;
    ret_row_nib  = 4'd0;
    ret_col_ctrl = 1'b0;
    ret_row_ctrl = 1'b0;
  endtask

  logic [3:0]  col_exp [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
  logic [3:0]  row_exp [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  logic        ctl_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] b2b_col [3] = '{16'h1357, 16'h2468, 16'h9ABC};
  logic [15:0] b2b_row [3] = '{16'h0F1E, 16'h2D3C, 16'h4B5A};

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_col_addr = 2'd0; cmd_row_addr = 2'd0;
    cmd_col_word = 16'd0; cmd_row_word = 16'd0; drain_req = 1'b0;
    ret_col_nib = 4'd0; ret_col_ctrl = 1'b0; ret_row_nib = 4'd0; ret_row_ctrl = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Start a frame, then reset in the middle of it.
    to_fcnt3();
    cmd_valid = 1'b1; cmd_col_addr = 2'd3; cmd_row_addr = 2'd3;
    cmd_col_word = 16'hFFFF; cmd_row_word = 16'hFFFF;
    tick();
    cmd_valid = 1'b0;
    check_vec("pre_rst_col_nib", 32'(col_nib), 32'hF);
    tick();
    rst = 1'b1;
    tick();
    check_vec("rst_col_nib",  32'(col_nib),  32'h0);
    check_vec("rst_row_nib",  32'(row_nib),  32'h0);
    check_vec("rst_col_ctrl", 32'(col_ctrl), 32'h0);
    check_vec("rst_row_ctrl", 32'(row_ctrl), 32'h0);
    check_vec("rst_busy",     32'(busy),     32'h0);
    check_vec("rst_ready",    32'(cmd_ready), 32'h0);
    check_vec("rst_drain",    32'(drain_done), 32'h0);
    check_vec("rst_rsp",      32'(rsp_valid), 32'h0);
    tick(); tick();
    check_vec("rst3_col_nib", 32'(col_nib), 32'h0);
    check_vec("rst3_rsp_word", 32'(rsp_col_word), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_vec($sformatf("post_rst_ready_c%0d", c), 32'(cmd_ready), 32'(c == 3));
      if (c < 3) tick();
    end

    // Single MAC command frame.
    cmd_valid = 1'b1; cmd_col_addr = 2'd1; cmd_row_addr = 2'd1;
    cmd_col_word = 16'hA5C3; cmd_row_word = 16'h1234;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("cmd_col_nib%0d", k),  32'(col_nib),  32'(col_exp[k]));
      check_vec($sformatf("cmd_row_nib%0d", k),  32'(row_nib),  32'(row_exp[k]));
      check_vec($sformatf("cmd_col_ctrl%0d", k), 32'(col_ctrl), 32'(ctl_exp[k]));
      check_vec($sformatf("cmd_row_ctrl%0d", k), 32'(row_ctrl), 32'(ctl_exp[k]));
      if (k == 0) check_vec("cmd_busy", 32'(busy), 32'h1);
      tick();
    end
    check_vec("idle_col_nib", 32'(col_nib), 32'h0);
    check_vec("idle_row_nib", 32'(row_nib), 32'h0);
    check_vec("idle_busy",    32'(busy),    32'h0);

    // cmd_valid held: three back-to-back frames, one accept every four cycles.
    to_fcnt3();
    cmd_valid = 1'b1; cmd_col_addr = 2'd1; cmd_row_addr = 2'd1;
    for (int f = 0; f < 3; f++) begin
      cmd_col_word = b2b_col[f];
      cmd_row_word = b2b_row[f];
      check_vec($sformatf("b2b_ready_f%0d", f), 32'(cmd_ready), 32'h1);
      tick();
      for (int k = 0; k < 4; k++) begin
        check_vec($sformatf("b2b_col_f%0d_k%0d", f, k), 32'(col_nib), 32'(b2b_col[f][15-4*k -: 4]));
        check_vec($sformatf("b2b_row_f%0d_k%0d", f, k), 32'(row_nib), 32'(b2b_row[f][15-4*k -: 4]));
        if (k < 3) begin
          check_vec($sformatf("b2b_noready_f%0d_k%0d", f, k), 32'(cmd_ready), 32'h0);
          tick();
        end else if (f == 2) begin
          cmd_valid = 1'b0;
        end
      end
    end
    tick();
    check_vec("b2b_tail_idle", 32'(col_nib), 32'h0);

    // Drain requested together with an accept.
    to_fcnt3();
    cmd_valid = 1'b1; drain_req = 1'b1; cmd_col_addr = 2'd1; cmd_row_addr = 2'd1;
    cmd_col_word = 16'hC001; cmd_row_word = 16'h7002;
    tick();
    cmd_valid = 1'b0; drain_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) begin
        check_vec("drn_cmd_col", 32'(col_nib), 32'hC);
        check_vec("drn_cmd_row", 32'(row_nib), 32'h7);
      end
      if (c >= 5 && c <= 12) begin
        check_vec($sformatf("drn_col_c%0d", c),   32'(col_nib),  32'h0);
        check_vec($sformatf("drn_row_c%0d", c),   32'(row_nib),  32'h0);
        check_vec($sformatf("drn_ctrl_c%0d", c),  32'({col_ctrl, row_ctrl}), 32'h0);
        check_vec($sformatf("drn_ready_c%0d", c), 32'(cmd_ready), 32'h0);
      end
      if (c <= 12) check_vec($sformatf("drn_busy_c%0d", c), 32'(busy), 32'h1);
      check_vec($sformatf("drn_done_c%0d", c), 32'(drain_done), 32'(c == 12));
      if (c == 13) check_vec("drn_busy_after", 32'(busy), 32'h0);
      if (c == 16) check_vec("drn_ready_after", 32'(cmd_ready), 32'h1);
      drain_req = (c == 7);
      if (c < 16) tick();
    end
    drain_req = 1'b0;

    // Returning frame with address 3 on both lanes.
    tick();
    rx_frame(16'hBEEF, 4'b1100, 16'h0042, 4'b1100);
    check_vec("rx_valid",    32'(rsp_valid),    32'h1);
    check_vec("rx_col_addr", 32'(rsp_col_addr), 32'h3);
    check_vec("rx_row_addr", 32'(rsp_row_addr), 32'h3);
    check_vec("rx_col_word", 32'(rsp_col_word), 32'hBEEF);
    check_vec("rx_row_word", 32'(rsp_row_word), 32'h0042);
    // All-pass frame: inputs stay zero, no pulse, response fields hold.
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_vec($sformatf("rx_idle_valid_c%0d", c), 32'(rsp_valid), 32'h0);
    end
    check_vec("rx_hold_col", 32'(rsp_col_word), 32'hBEEF);
    check_vec("rx_hold_row", 32'(rsp_row_word), 32'h0042);

    // Only the column lane carries an address.
    to_fcnt3();
    tick();
    rx_frame(16'h5A69, 4'b1000, 16'h0000, 4'b0000);
    check_vec("rx2_valid",    32'(rsp_valid),    32'h1);
    check_vec("rx2_col_addr", 32'(rsp_col_addr), 32'h2);
    check_vec("rx2_row_addr", 32'(rsp_row_addr), 32'h0);
    check_vec("rx2_col_word", 32'(rsp_col_word), 32'h5A69);
    tick();
    check_vec("rx2_pulse_end", 32'(rsp_valid), 32'h0);

`ifdef SYSTOLIC_SEQ_STATS_EN
    check_vec("stat_mac", 32'(stat_mac), 32'd5);
    check_vec("stat_rsp", 32'(stat_rsp), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
